// File: rtl/m_mem_pkg.sv
// Shared encodings for the memory access unit: access sizes, error codes,
// FSM state values and the byte-lane mask helper.
package m_mem_pkg;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;
  localparam logic [1:0] SIZE_D = 2'd3;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_BUSY = 2'd1;
  localparam state_t ST_RESP = 2'd2;

  // One bit per byte touched by an access of the given size, right-justified.
  function automatic logic [7:0] lane_mask(input logic [1:0] size);
    case (size)
      SIZE_B:  return 8'h01;
      SIZE_H:  return 8'h03;
      SIZE_W:  return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/m_mem_bus_if.sv
// MIO bus seen by the access unit: the unit is master, memory is slave.
// A bus cycle runs while bus_req=1 and completes on the rising edge where bus_ack=1;
// the master holds every bus_* field stable until that edge.
interface m_mem_bus_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  localparam int LANES = DATA_W / 8;

  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [LANES-1:0]  bus_be;
  logic [DATA_W-1:0] bus_wdata;
  logic [DATA_W-1:0] bus_rdata;
  logic              bus_ack;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_rdata, bus_ack
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_rdata, bus_ack
  );
endinterface

// File: rtl/m_lane_align.sv
// Byte-lane steering: store replication and byte enables on the way out,
// load shift plus sign/zero extension on the way back.
module m_lane_align
  import m_mem_pkg::*;
#(
  parameter  int DATA_W = 32,
  localparam int LANES  = DATA_W / 8,
  localparam int OFFS   = $clog2(LANES)
) (
  input  logic [1:0]        st_size,
  input  logic [OFFS-1:0]   st_offs,
  input  logic [DATA_W-1:0] st_data,
  output logic [LANES-1:0]  st_be,
  output logic [DATA_W-1:0] st_wdata,
  input  logic [1:0]        ld_size,
  input  logic [OFFS-1:0]   ld_offs,
  input  logic              ld_sign,
  input  logic [DATA_W-1:0] ld_raw,
  output logic [DATA_W-1:0] ld_data
);

  logic [7:0]        lm_st;
  logic [7:0]        lm_ld;
  logic [LANES-1:0]  st_lanes;
  logic [LANES-1:0]  ld_lanes;
  logic [OFFS-1:0]   idx_mask;
  logic [DATA_W-1:0] shifted;
  logic              fill;

  always_comb begin
    lm_st    = lane_mask(st_size);
    st_lanes = LANES'(lm_st);
    st_be    = st_lanes << st_offs;
    // Byte index modulo the access width: lane i repeats source byte (i mod 2^size).
    idx_mask = OFFS'({st_size == SIZE_D, st_size[1], |st_size});
    st_wdata = '0;
    for (int i = 0; i < LANES; i++) begin
      st_wdata[8*i +: 8] = st_data[8*(OFFS'(i) & idx_mask) +: 8];
    end
  end

  always_comb begin
    shifted  = ld_raw >> {ld_offs, 3'b000};
    lm_ld    = lane_mask(ld_size);
    ld_lanes = LANES'(lm_ld);
    case (ld_size)
      SIZE_B:  fill = shifted[7];
      SIZE_H:  fill = shifted[15];
      SIZE_W:  fill = shifted[31];
      default: fill = shifted[DATA_W-1];
    endcase
    fill    = fill & ld_sign;
    ld_data = '0;
    for (int i = 0; i < LANES; i++) begin
      ld_data[8*i +: 8] = ld_lanes[i] ? shifted[8*i +: 8] : {8{fill}};
    end
  end

endmodule

// File: rtl/m_mem_access_unit.sv
// Load/store engine between the datapath and the MIO bus: alignment check,
// lane steering, ack handshake with wait-state timeout, registered results.
module m_mem_access_unit
  import m_mem_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  // req is taken on a rising edge where ready=1; the result appears with a
  // one-cycle done pulse, err and rdata valid alongside it.
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic              done,
  output logic [1:0]        err,
  output logic [DATA_W-1:0] rdata,
  output state_t            state_dbg,
  m_mem_bus_if.master       bus
);

  localparam int LANES = DATA_W / 8;
  localparam int OFFS  = $clog2(LANES);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              lat_we;
  logic [1:0]        lat_size;
  logic              lat_sign;
  logic [OFFS-1:0]   lat_offs;
  logic              misalign;
  logic [LANES-1:0]  st_be;
  logic [DATA_W-1:0] st_wdata;
  logic [DATA_W-1:0] ld_data;

  always_comb begin
    case (size)
      SIZE_B:  misalign = 1'b0;
      SIZE_H:  misalign = addr[0];
      SIZE_W:  misalign = |addr[1:0];
      default: misalign = (DATA_W != 64) || (|addr[2:0]);
    endcase
  end

  m_lane_align #(.DATA_W(DATA_W)) u_align (
    .st_size  (size),
    .st_offs  (addr[OFFS-1:0]),
    .st_data  (wdata),
    .st_be    (st_be),
    .st_wdata (st_wdata),
    .ld_size  (lat_size),
    .ld_offs  (lat_offs),
    .ld_sign  (lat_sign),
    .ld_raw   (bus.bus_rdata),
    .ld_data  (ld_data)
  );

  assign ready     = (state == ST_IDLE);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      lat_we        <= 1'b0;
      lat_size      <= SIZE_B;
      lat_sign      <= 1'b0;
      lat_offs      <= '0;
      done          <= 1'b0;
      err           <= ERR_OK;
      rdata         <= '0;
      bus.bus_req   <= 1'b0;
      bus.bus_we    <= 1'b0;
      bus.bus_addr  <= '0;
      bus.bus_be    <= '0;
      bus.bus_wdata <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: if (req) begin
          if (misalign) begin
            state <= ST_RESP;
            done  <= 1'b1;
            err   <= ERR_MISALIGN;
            rdata <= '0;
          end else begin
            state         <= ST_BUSY;
            cnt           <= '0;
            lat_we        <= we;
            lat_size      <= size;
            lat_sign      <= sign_ext;
            lat_offs      <= addr[OFFS-1:0];
            bus.bus_req   <= 1'b1;
            bus.bus_we    <= we;
            bus.bus_addr  <= {addr[ADDR_W-1:OFFS], {OFFS{1'b0}}};
            bus.bus_be    <= we ? st_be : '1;
            bus.bus_wdata <= st_wdata;
          end
        end
        ST_BUSY: begin
          // An ack on the last allowed wait cycle still completes normally.
          if (bus.bus_ack) begin
            state       <= ST_RESP;
            done        <= 1'b1;
            err         <= ERR_OK;
            rdata       <= lat_we ? '0 : ld_data;
            bus.bus_req <= 1'b0;
          end else if (TIMEOUT != 0 && cnt == TO_LAST) begin
            state       <= ST_RESP;
            done        <= 1'b1;
            err         <= ERR_TIMEOUT;
            rdata       <= '0;
            bus.bus_req <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_m_mem_access_unit.sv
// Directed bench for m_mem_access_unit (DATA_W=32, TIMEOUT=4): loads, stores,
// misalignment, timeout boundary and asynchronous reset mid-access.
module tb_m_mem_access_unit;
  import m_mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  size = SIZE_W;
  logic        sign_ext = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        ready;
  logic        done;
  logic [1:0]  err;
  logic [31:0] rdata;
  state_t      state_dbg;

  m_mem_bus_if #(.DATA_W(32), .ADDR_W(32)) bus_if ();

  m_mem_access_unit #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .we        (we),
    .size      (size),
    .sign_ext  (sign_ext),
    .addr      (addr),
    .wdata     (wdata),
    .ready     (ready),
    .done      (done),
    .err       (err),
    .rdata     (rdata),
    .state_dbg (state_dbg),
    .bus       (bus_if.master)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  // values seen on the bus in cycle 1 of the latest access
  logic        c_req;
  logic        c_we;
  logic [31:0] c_addr;
  logic [3:0]  c_be;
  logic [31:0] c_wd;
  logic        stable_ok;
  int          done_cyc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one request, act as memory (ack during cycle ack_cyc, -1 = never),
  // then check completion cycle, err, optional rdata from exp_q, and the pulse shape.
  task automatic access(input string tag, input logic w, input logic [1:0] sz, input logic sx,
                        input logic [31:0] a, input logic [31:0] wd, input int ack_cyc,
                        input logic [31:0] raw, input bit noise, input int exp_done,
                        input logic [1:0] exp_err, input bit chk_rd);
    int cyc;
    logic [31:0] e;
    @(negedge clk);
    req = 1'b1; we = w; size = sz; sign_ext = sx; addr = a; wdata = wd;
    @(negedge clk);
    req = noise;
    if (noise) begin
      addr = 32'h0000_0203; we = ~w; size = SIZE_B; sign_ext = ~sx; wdata = '1;
    end
    c_req = bus_if.bus_req; c_we = bus_if.bus_we; c_addr = bus_if.bus_addr;
    c_be = bus_if.bus_be; c_wd = bus_if.bus_wdata;
    stable_ok = 1'b1;
    done_cyc = -1;
    cyc = 1;
    while (cyc <= 20) begin
      if (done) begin
        done_cyc = cyc;
        break;
      end
      if (bus_if.bus_req !== c_req || bus_if.bus_we !== c_we || bus_if.bus_addr !== c_addr ||
          bus_if.bus_be !== c_be || bus_if.bus_wdata !== c_wd) stable_ok = 1'b0;
      bus_if.bus_ack = (cyc == ack_cyc);
      bus_if.bus_rdata = raw;
      @(negedge clk);
      bus_if.bus_ack = 1'b0;
      cyc++;
    end
    req = 1'b0;
    check({tag, "_done_cycle"}, 32'(done_cyc), 32'(exp_done));
    check({tag, "_err"}, 32'(err), 32'(exp_err));
    check({tag, "_bus_req_at_done"}, 32'(bus_if.bus_req), 32'd0);
    if (chk_rd) begin
      e = exp_q.pop_front();
      check({tag, "_rdata"}, rdata, e);
    end
    @(negedge clk);
    check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
    check({tag, "_ready_after"}, 32'(ready), 32'd1);
  endtask

  initial begin
    int seen;
    bus_if.bus_ack = 1'b0;
    bus_if.bus_rdata = '0;

    // reset values
    @(negedge clk);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    check("rst_bus_req", 32'(bus_if.bus_req), 32'd0);
    check("rst_bus_we", 32'(bus_if.bus_we), 32'd0);
    check("rst_bus_addr", bus_if.bus_addr, 32'd0);
    check("rst_bus_be", 32'(bus_if.bus_be), 32'd0);
    check("rst_bus_wdata", bus_if.bus_wdata, 32'd0);
    reset = 1'b1;

    // lw 0x100, three wait cycles, req held high while busy (must be ignored)
    exp_q.push_back(32'h1234_5678);
    access("lw_100", 1'b0, SIZE_W, 1'b0, 32'h100, 32'h0, 4, 32'h1234_5678, 1'b1, 5, ERR_OK, 1'b1);
    check("lw_100_bus_req", 32'(c_req), 32'd1);
    check("lw_100_bus_we", 32'(c_we), 32'd0);
    check("lw_100_bus_addr", c_addr, 32'h100);
    check("lw_100_bus_be", 32'(c_be), 32'hF);
    check("lw_100_stable", 32'(stable_ok), 32'd1);

    // byte and half loads with extension
    exp_q.push_back(32'hFFFF_FF80);
    access("lb_103", 1'b0, SIZE_B, 1'b1, 32'h103, 32'h0, 1, 32'h8012_3456, 1'b0, 2, ERR_OK, 1'b1);
    check("lb_103_bus_addr", c_addr, 32'h100);
    check("lb_103_bus_be", 32'(c_be), 32'hF);
    exp_q.push_back(32'h0000_0080);
    access("lbu_103", 1'b0, SIZE_B, 1'b0, 32'h103, 32'h0, 2, 32'h8012_3456, 1'b0, 3, ERR_OK, 1'b1);
    exp_q.push_back(32'hFFFF_ABCD);
    access("lh_102", 1'b0, SIZE_H, 1'b1, 32'h102, 32'h0, 1, 32'hABCD_1234, 1'b0, 2, ERR_OK, 1'b1);
    exp_q.push_back(32'h0000_00F7);
    access("lbu_101", 1'b0, SIZE_B, 1'b0, 32'h101, 32'h0, 1, 32'h0000_F700, 1'b0, 2, ERR_OK, 1'b1);

    // stores: byte enables and replication
    access("sh_102", 1'b1, SIZE_H, 1'b0, 32'h102, 32'h0000_BEEF, 1, 32'h0, 1'b0, 2, ERR_OK, 1'b0);
    check("sh_102_bus_we", 32'(c_we), 32'd1);
    check("sh_102_bus_be", 32'(c_be), 32'hC);
    check("sh_102_bus_wdata", c_wd, 32'hBEEF_BEEF);
    check("sh_102_bus_addr", c_addr, 32'h100);
    access("sb_101", 1'b1, SIZE_B, 1'b0, 32'h101, 32'h0000_00A5, 1, 32'h0, 1'b0, 2, ERR_OK, 1'b0);
    check("sb_101_bus_be", 32'(c_be), 32'h2);
    check("sb_101_bus_wdata", c_wd, 32'hA5A5_A5A5);
    // ack on the last allowed wait cycle wins over the timeout
    access("sw_104", 1'b1, SIZE_W, 1'b0, 32'h104, 32'hCAFE_F00D, 4, 32'h0, 1'b1, 5, ERR_OK, 1'b0);
    check("sw_104_bus_be", 32'(c_be), 32'hF);
    check("sw_104_bus_wdata", c_wd, 32'hCAFE_F00D);
    check("sw_104_bus_addr", c_addr, 32'h104);
    check("sw_104_stable", 32'(stable_ok), 32'd1);

    // misaligned requests: no bus cycle, done at cycle 1
    exp_q.push_back(32'h0);
    access("lw_101", 1'b0, SIZE_W, 1'b0, 32'h101, 32'h0, -1, 32'hFFFF_FFFF, 1'b0, 1, ERR_MISALIGN, 1'b1);
    check("lw_101_bus_req", 32'(c_req), 32'd0);
    exp_q.push_back(32'h0);
    access("sd_100", 1'b1, SIZE_D, 1'b0, 32'h100, 32'h1, -1, 32'h0, 1'b0, 1, ERR_MISALIGN, 1'b1);
    check("sd_100_bus_req", 32'(c_req), 32'd0);
    exp_q.push_back(32'h0);
    access("lh_103", 1'b0, SIZE_H, 1'b0, 32'h103, 32'h0, -1, 32'h0, 1'b0, 1, ERR_MISALIGN, 1'b1);

    // timeout after 4 BUSY cycles without ack
    exp_q.push_back(32'h0);
    access("lw_to", 1'b0, SIZE_W, 1'b0, 32'h108, 32'h0, -1, 32'h5555_5555, 1'b0, 5, ERR_TIMEOUT, 1'b1);
    check("lw_to_bus_req", 32'(c_req), 32'd1);

    // asynchronous reset in the middle of a bus cycle
    @(negedge clk);
    req = 1'b1; we = 1'b0; size = SIZE_W; addr = 32'h110;
    @(negedge clk);
    req = 1'b0;
    check("rst_mid_bus_req_before", 32'(bus_if.bus_req), 32'd1);
    @(negedge clk);
    #1 reset = 1'b0;
    #1;
    check("rst_mid_bus_req", 32'(bus_if.bus_req), 32'd0);
    check("rst_mid_ready", 32'(ready), 32'd1);
    check("rst_mid_state", 32'(state_dbg), 32'(ST_IDLE));
    @(negedge clk);
    reset = 1'b1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done) seen++;
    end
    check("rst_mid_no_done", 32'(seen), 32'd0);
    check("rst_mid_ready_after", 32'(ready), 32'd1);
    exp_q.push_back(32'hDEAD_BEEF);
    access("lw_10c", 1'b0, SIZE_W, 1'b0, 32'h10C, 32'h0, 2, 32'hDEAD_BEEF, 1'b0, 3, ERR_OK, 1'b1);
    check("lw_10c_bus_addr", c_addr, 32'h10C);

    // report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
